// File: rtl/crp16_alu_shift_arbiter.sv
// Shares one 16-bit left barrel shifter between ALU (req0) and address unit (req1); 5-bit amount, >=16 yields 0.
// Latency: accept at T, response valid at T+2; one op in flight, requests stall (ready low) until response is consumed.

module crp16_alu_shifter_left (
    input  logic [15:0] x_i,
    input  logic [3:0]  shamt_i,
    output logic [15:0] y_o
);
    logic [15:0] stage1;
    logic [15:0] stage2;
    logic [15:0] stage4;

    assign stage1 = shamt_i[0] ? {x_i[14:0], 1'b0}    : x_i;
    assign stage2 = shamt_i[1] ? {stage1[13:0], 2'b0} : stage1;
    assign stage4 = shamt_i[2] ? {stage2[11:0], 4'b0} : stage2;
    assign y_o    = shamt_i[3] ? {stage4[7:0], 8'b0}  : stage4;
endmodule

module crp16_alu_shift_arbiter #(
    parameter bit RR_ENABLE = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [15:0] req0_x,
    input  logic [4:0]  req0_shift,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [15:0] req1_x,
    input  logic [4:0]  req1_shift,
    output logic        rsp0_valid,
    output logic [15:0] rsp0_data,
    input  logic        rsp0_ready,
    output logic        rsp1_valid,
    output logic [15:0] rsp1_data,
    input  logic        rsp1_ready,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    typedef struct packed {
        logic [15:0] x;
        logic [4:0]  shift;
    } shift_op_t;

    state_t      state_q, state_d;
    shift_op_t   op_q, op_d;
    logic        owner_q, owner_d;
    logic        last_grant_q, last_grant_d;
    logic [15:0] result_q, result_d;

    logic        grant;
    logic        any_req;
    logic        rsp_done;
    logic [15:0] shifter_out;

    crp16_alu_shifter_left u_shifter (
        .x_i     (op_q.x),
        .shamt_i (op_q.shift[3:0]),
        .y_o     (shifter_out)
    );

    // Ties go to whoever did not win last time; fixed-priority builds always favour req0.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = RR_ENABLE ? ~last_grant_q : 1'b0;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    assign any_req    = req0_valid || req1_valid;
    assign req0_ready = (state_q == IDLE) && req0_valid && (grant == 1'b0);
    assign req1_ready = (state_q == IDLE) && req1_valid && (grant == 1'b1);
    assign rsp_done   = owner_q ? rsp1_ready : rsp0_ready;

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        result_d     = result_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    op_d.x       = grant ? req1_x : req0_x;
                    op_d.shift   = grant ? req1_shift : req0_shift;
                    owner_d      = grant;
                    last_grant_d = grant;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                result_d = op_q.shift[4] ? 16'h0000 : shifter_out;
                state_d  = RESP;
            end
            RESP: begin
                if (rsp_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            op_q         <= '0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            result_q     <= 16'h0000;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            result_q     <= result_d;
        end
    end

    // Non-owner channel is forced to zero so a stale result never leaks across requesters.
    assign rsp0_valid = (state_q == RESP) && !owner_q;
    assign rsp1_valid = (state_q == RESP) && owner_q;
    assign rsp0_data  = rsp0_valid ? result_q : 16'h0000;
    assign rsp1_data  = rsp1_valid ? result_q : 16'h0000;
    assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_crp16_alu_shift_arbiter.sv
// Directed bench for crp16_alu_shift_arbiter: round-robin instance plus a fixed-priority instance on shared stimulus.
module tb_crp16_alu_shift_arbiter;
    logic        clock;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic [15:0] req0_x, req1_x;
    logic [4:0]  req0_shift, req1_shift;
    logic        rsp0_ready, rsp1_ready;

    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy;
    logic [15:0] rsp0_data, rsp1_data;
    logic        fp_req0_ready, fp_req1_ready, fp_rsp0_valid, fp_rsp1_valid, fp_busy;
    logic [15:0] fp_rsp0_data, fp_rsp1_data;

    int n_checks;
    int n_errors;

    crp16_alu_shift_arbiter #(.RR_ENABLE(1'b1)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_shift(req0_shift),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_shift(req1_shift),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_ready(rsp1_ready),
        .busy(busy)
    );

    crp16_alu_shift_arbiter #(.RR_ENABLE(1'b0)) dut_fp (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_x(req0_x), .req0_shift(req0_shift),
        .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_x(req1_x), .req1_shift(req1_shift),
        .rsp0_valid(fp_rsp0_valid), .rsp0_data(fp_rsp0_data), .rsp0_ready(rsp0_ready),
        .rsp1_valid(fp_rsp1_valid), .rsp1_data(fp_rsp1_data), .rsp1_ready(rsp1_ready),
        .busy(fp_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One isolated request; checks grant, latency to response, data and the idle response channel.
    task automatic run_op(input bit port, input logic [15:0] x, input logic [4:0] sh,
                          input logic [15:0] exp, input string tag);
        int cyc;
        @(negedge clock);
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        if (port) begin
            req1_valid = 1'b1; req1_x = x; req1_shift = sh;
        end else begin
            req0_valid = 1'b1; req0_x = x; req0_shift = sh;
        end
        #1;
        check_eq({tag, "_rdy"}, port ? req1_ready : req0_ready, 1);
        @(negedge clock);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        cyc = 1;
        #1;
        while (!(port ? rsp1_valid : rsp0_valid) && cyc < 8) begin
            @(negedge clock);
            #1;
            cyc++;
        end
        check_eq({tag, "_lat"}, cyc, 2);
        check_eq({tag, "_dat"}, port ? rsp1_data : rsp0_data, exp);
        check_eq({tag, "_other"}, port ? rsp0_valid : rsp1_valid, 0);
    endtask

    // Reset lands in the EXEC cycle of an operation from 'port'; afterwards a tie must go to req0.
    task automatic reset_mid(input bit port, input string tag);
        @(negedge clock);
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        if (port) begin
            req1_valid = 1'b1; req1_x = 16'h00FF; req1_shift = 5'd1;
        end else begin
            req0_valid = 1'b1; req0_x = 16'h00FF; req0_shift = 5'd1;
        end
        #1;
        check_eq({tag, "_acc"}, port ? req1_ready : req0_ready, 1);
        @(negedge clock);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        reset = 1'b1;
        #1;
        check_eq({tag, "_exec_busy"}, busy, 1);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_eq({tag, "_post_v"}, {rsp0_valid, rsp1_valid, req0_ready, req1_ready, busy}, 5'b0);
        @(negedge clock);
        req0_valid = 1'b1; req0_x = 16'h0001; req0_shift = 5'd1;
        req1_valid = 1'b1; req1_x = 16'h0003; req1_shift = 5'd2;
        #1;
        check_eq({tag, "_tie"}, {req0_ready, req1_ready}, 2'b10);
        @(negedge clock);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        @(negedge clock);
        #1;
        check_eq({tag, "_res"}, {rsp0_valid, rsp0_data}, {1'b1, 16'h0002});
        @(negedge clock);
    endtask

    int          g_cyc [8];
    int          g_who [8];
    logic [15:0] d_seq [8];
    int          ng, nd, fp0, fp1, fpr0, fpr1;

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        reset      = 1'b1;
        req0_valid = 1'b0; req0_x = '0; req0_shift = '0;
        req1_valid = 1'b0; req1_x = '0; req1_shift = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;

        repeat (3) @(negedge clock);
        #1;
        check_eq("rst_valids", {rsp0_valid, rsp1_valid, busy}, 3'b0);
        check_eq("rst_data", {rsp0_data, rsp1_data}, 32'h0);
        check_eq("rst_ready", {req0_ready, req1_ready}, 2'b0);
        reset = 1'b0;

        run_op(1'b0, 16'h00F3, 5'd4,  16'h0F30, "single0");
        run_op(1'b0, 16'hA5C3, 5'd8,  16'hC300, "r0_sh8");
        run_op(1'b1, 16'hFFFF, 5'd16, 16'h0000, "sat16");
        run_op(1'b1, 16'hFFFF, 5'd31, 16'h0000, "sat31");
        run_op(1'b1, 16'hFFFF, 5'd15, 16'h8000, "sh15");
        run_op(1'b1, 16'hFFFF, 5'd0,  16'hFFFF, "sh0");

        // Continuous contention on both instances.
        for (int k = 0; k < 8; k++) begin
            g_cyc[k] = -1; g_who[k] = 9; d_seq[k] = 16'hDEAD;
        end
        ng = 0; nd = 0; fp0 = 0; fp1 = 0; fpr0 = 0; fpr1 = 0;
        @(negedge clock);
        req0_valid = 1'b1; req0_x = 16'h0001; req0_shift = 5'd1;
        req1_valid = 1'b1; req1_x = 16'h0003; req1_shift = 5'd2;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clock);
            #1;
            if (req0_ready && ng < 8) begin g_cyc[ng] = i; g_who[ng] = 0; ng++; end
            if (req1_ready && ng < 8) begin g_cyc[ng] = i; g_who[ng] = 1; ng++; end
            if (rsp0_valid && nd < 8) begin d_seq[nd] = rsp0_data; nd++; end
            if (rsp1_valid && nd < 8) begin d_seq[nd] = rsp1_data; nd++; end
            if (fp_req0_ready) fp0++;
            if (fp_req1_ready) fp1++;
            if (fp_rsp0_valid) fpr0++;
            if (fp_rsp1_valid) fpr1++;
        end
        check_eq("rr_grants", ng, 4);
        check_eq("rr_resps", nd, 4);
        for (int k = 0; k < 4; k++) begin
            check_eq($sformatf("rr_who%0d", k), g_who[k], k % 2);
            check_eq($sformatf("rr_cyc%0d", k), g_cyc[k], 3 * k);
            check_eq($sformatf("rr_dat%0d", k), d_seq[k], (k % 2) ? 16'h000C : 16'h0002);
        end
        check_eq("fp_req0_grants", fp0, 4);
        check_eq("fp_req1_ready", fp1, 0);
        check_eq("fp_rsp0", fpr0, 4);
        check_eq("fp_rsp1", fpr1, 0);
        @(negedge clock);
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Backpressure on rsp0 while req1 waits.
        @(negedge clock);
        rsp0_ready = 1'b0;
        req0_valid = 1'b1; req0_x = 16'h1234; req0_shift = 5'd0;
        #1;
        check_eq("bp_acc", req0_ready, 1);
        @(negedge clock);
        req0_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            req1_valid = 1'b1; req1_x = 16'h0003; req1_shift = 5'd2;
            #1;
            check_eq($sformatf("bp_hold%0d", i), {rsp0_valid, rsp0_data}, {1'b1, 16'h1234});
            check_eq($sformatf("bp_rdy%0d", i), {req0_ready, req1_ready, rsp1_valid}, 3'b0);
        end
        @(negedge clock);
        rsp0_ready = 1'b1;
        #1;
        check_eq("bp_release", {rsp0_valid, rsp0_data}, {1'b1, 16'h1234});
        @(negedge clock);
        #1;
        check_eq("bp_done", rsp0_valid, 0);
        check_eq("bp_next_req1", req1_ready, 1);
        @(negedge clock);
        req1_valid = 1'b0;
        @(negedge clock);
        #1;
        check_eq("bp_req1_res", {rsp1_valid, rsp1_data}, {1'b1, 16'h000C});
        @(negedge clock);

        reset_mid(1'b1, "rst_mid1");
        reset_mid(1'b0, "rst_mid0");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
